// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly scheduler: transform-size
// constants, the scheduler state encoding and a reference address function.
package ntt_pkg;

   localparam int NTT_LOGN    = 8;
   localparam int NTT_N       = 1 << NTT_LOGN;
   localparam int NTT_MAX_OUT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] tf;
   } bu_addr_t;

   // Butterfly b of stage s in an N = 2^logn point in-place Cooley-Tukey NTT.
   function automatic bu_addr_t bu_addr(input int unsigned logn,
                                        input int unsigned s,
                                        input int unsigned b);
      int unsigned len;
      int unsigned g;
      int unsigned off;
      bu_addr_t    r;
      len  = (32'd1 << logn) >> (s + 32'd1);
      g    = b >> (logn - 32'd1 - s);
      off  = b & (len - 32'd1);
      r.x  = g * 32'd2 * len + off;
      r.y  = r.x + len;
      r.tf = (32'd1 << s) + g;
      return r;
   endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational (stage, butterfly index) -> X/Y/twiddle address generator.
// X is b with a zero bit inserted at position LOGN-1-s; Y sets that bit.
module ntt_addr_gen
   import ntt_pkg::*;
#(
   parameter int  LOGN = NTT_LOGN,
   localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1
) (
   input  logic [SW-1:0]   s_i,
   input  logic [LOGN-2:0] b_i,
   output logic [LOGN-1:0] x_o,
   output logic [LOGN-1:0] y_o,
   output logic [LOGN-1:0] tf_o
);

   logic [SW-1:0]   k;
   logic [LOGN-1:0] b_ext;
   logic [LOGN-1:0] len;
   logic [LOGN-1:0] mask;
   logic [LOGN-1:0] g;

   // Split b into group (high bits) and offset (low bits) and rebuild addresses.
   always_comb begin
      k     = SW'(LOGN - 1) - s_i;
      b_ext = {1'b0, b_i};
      len   = LOGN'(1) << k;
      mask  = len - LOGN'(1);
      g     = b_ext >> k;
      x_o   = ((b_ext & ~mask) << 1) | (b_ext & mask);
      y_o   = x_o | len;
      tf_o  = (LOGN'(1) << s_i) | g;
   end

endmodule

// File: rtl/ntt_bu_sched.sv
// Butterfly scheduler: walks all stages/butterflies of the NTT, issues one op
// per handshake, tracks ops in flight and drains the pipeline between stages.
//
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | offering butterflies of stage s, b advances on each fire
//   DRAIN | all ops of stage s issued, waiting for outstanding == 0
//   DONE  | one-cycle completion pulse
module ntt_bu_sched
   import ntt_pkg::*;
#(
   parameter int  LOGN    = NTT_LOGN,
   parameter int  MAX_OUT = NTT_MAX_OUT,
   localparam int SW      = (LOGN > 1) ? $clog2(LOGN) : 1,
   localparam int OW      = $clog2(MAX_OUT + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            op_valid_o,
   input  logic            op_ready_i,
   output logic [LOGN-1:0] op_x_addr_o,
   output logic [LOGN-1:0] op_y_addr_o,
   output logic [LOGN-1:0] op_tf_addr_o,
   output logic [SW-1:0]   stage_o,
   input  logic            wb_valid_i,
   output logic            err_o
);

   state_e          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [LOGN-2:0] b_q, b_d;
   logic [OW-1:0]   out_q, out_d;
   logic            err_q, err_d;
   logic            fire;
   logic            wb_ok;
   logic            issuing;
   logic [LOGN-1:0] x, y, tf;

   ntt_addr_gen #(.LOGN(LOGN)) u_addr (
      .s_i  (s_q),
      .b_i  (b_q),
      .x_o  (x),
      .y_o  (y),
      .tf_o (tf)
   );

   assign issuing      = (state_q == ISSUE);
   assign op_valid_o   = issuing && (out_q < OW'(MAX_OUT));
   assign fire         = op_valid_o && op_ready_i;
   // A writeback with nothing in flight is an engine fault, not a decrement.
   assign wb_ok        = wb_valid_i && (out_q != '0);
   assign busy_o       = issuing || (state_q == DRAIN);
   assign done_o       = (state_q == DONE);
   assign stage_o      = s_q;
   assign err_o        = err_q;
   assign op_x_addr_o  = issuing ? x  : '0;
   assign op_y_addr_o  = issuing ? y  : '0;
   assign op_tf_addr_o = issuing ? tf : '0;

   // Ops in flight: up on fire, down on a legal writeback.
   always_comb begin
      out_d = out_q;
      if (fire && !wb_ok) begin
         out_d = out_q + 1'b1;
      end else if (!fire && wb_ok) begin
         out_d = out_q - 1'b1;
      end
   end

   // Next-state logic for the FSM, stage/butterfly counters and sticky error.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      b_d     = b_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = ISSUE;
               s_d     = '0;
               b_d     = '0;
               err_d   = 1'b0;
            end
         end
         ISSUE: begin
            if (fire) begin
               if (b_q == '1) begin
                  state_d = DRAIN;
               end else begin
                  b_d = b_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_q == '0) begin
               if (s_q == SW'(LOGN - 1)) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  s_d     = s_q + 1'b1;
                  b_d     = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (wb_valid_i && (out_q == '0)) begin
         err_d = 1'b1;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         b_q     <= b_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

endmodule
